// File: rtl/control_pipe_decoder.sv
// Registered main decoder: decodes opcode/funct3 into the control bundle and
// carries it through PIPE_DEPTH stages with stall, flush and illegal tracking.
module control_pipe_decoder #(
   parameter int PIPE_DEPTH  = 1,
   parameter int BRANCH_FULL = 1,
   parameter int ILL_CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 out_valid,
   output logic                 RegWrite,
   output logic [2:0]           ImmSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic                 MemWrite,
   output logic [1:0]           ResultSrc,
   output logic                 Branch,
   output logic [2:0]           BranchCond,
   output logic [1:0]           ALUOp,
   output logic                 Jump,
   output logic                 illegal,
   output logic [ILL_CNT_W-1:0] ill_count
);

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic [2:0] immSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       memWrite;
      logic [1:0] resultSrc;
      logic       branch;
      logic [2:0] branchCond;
      logic [1:0] aluOp;
      logic       jump;
      logic       illegal;
   } ctrlBundle;

   localparam logic [ILL_CNT_W-1:0] cntOne = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

   ctrlBundle decoded;
   ctrlBundle outStage;
   ctrlBundle stageQ [PIPE_DEPTH];
   logic      branchLegal;
   logic      illLeaving;
   logic [ILL_CNT_W-1:0] illCntQ;

   // funct3 010/011 are never valid branches; the reduced decoder keeps only BEQ/BNE.
   always_comb begin
      if (BRANCH_FULL != 0) begin
         branchLegal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end else begin
         branchLegal = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
   end

   always_comb begin
      decoded = '0;
      if (in_valid) begin
         case (op)
            7'h03: begin
               decoded.valid     = 1'b1;
               decoded.regWrite  = 1'b1;
               decoded.aluSrcB   = 2'b01;
               decoded.resultSrc = 2'b01;
            end
            7'h23: begin
               decoded.valid    = 1'b1;
               decoded.immSrc   = 3'b001;
               decoded.aluSrcB  = 2'b01;
               decoded.memWrite = 1'b1;
            end
            7'h33: begin
               decoded.valid    = 1'b1;
               decoded.regWrite = 1'b1;
               decoded.aluOp    = 2'b10;
            end
            7'h13: begin
               decoded.valid    = 1'b1;
               decoded.regWrite = 1'b1;
               decoded.aluSrcB  = 2'b01;
               decoded.aluOp    = 2'b10;
            end
            7'h63: begin
               decoded.valid = 1'b1;
               if (branchLegal) begin
                  decoded.immSrc     = 3'b010;
                  decoded.branch     = 1'b1;
                  decoded.branchCond = funct3;
                  decoded.aluOp      = 2'b01;
               end else begin
                  decoded.illegal = 1'b1;
               end
            end
            7'h6F: begin
               decoded.valid     = 1'b1;
               decoded.regWrite  = 1'b1;
               decoded.immSrc    = 3'b011;
               decoded.resultSrc = 2'b10;
               decoded.jump      = 1'b1;
            end
            7'h67: begin
               decoded.valid     = 1'b1;
               decoded.regWrite  = 1'b1;
               decoded.aluSrcB   = 2'b01;
               decoded.resultSrc = 2'b10;
               decoded.jump      = 1'b1;
            end
            7'h17: begin
               decoded.valid    = 1'b1;
               decoded.regWrite = 1'b1;
               decoded.immSrc   = 3'b100;
               decoded.aluSrcA  = 1'b1;
               decoded.aluSrcB  = 2'b10;
            end
            7'h37: begin
               decoded.valid    = 1'b1;
               decoded.regWrite = 1'b1;
               decoded.immSrc   = 3'b100;
               decoded.aluSrcA  = 1'b1;
               decoded.aluSrcB  = 2'b01;
            end
            7'h00: begin
               decoded = '0;
            end
            default: begin
               decoded.valid   = 1'b1;
               decoded.illegal = 1'b1;
            end
         endcase
      end
   end

   // Flush takes priority over stall so a held pipe can still be emptied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_DEPTH; k++) stageQ[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < PIPE_DEPTH; k++) stageQ[k] <= '0;
      end else if (!stall) begin
         stageQ[0] <= decoded;
         for (int k = 1; k < PIPE_DEPTH; k++) stageQ[k] <= stageQ[k-1];
      end
   end

   assign outStage = stageQ[PIPE_DEPTH-1];

   // An illegal entry is counted once, on the edge where it leaves the output stage.
   assign illLeaving = outStage.valid && outStage.illegal && (!stall || flush);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illCntQ <= '0;
      end else if (illLeaving && (illCntQ != '1)) begin
         illCntQ <= illCntQ + cntOne;
      end
   end

   assign out_valid  = outStage.valid;
   assign RegWrite   = outStage.regWrite;
   assign ImmSrc     = outStage.immSrc;
   assign ALUSrcA    = outStage.aluSrcA;
   assign ALUSrcB    = outStage.aluSrcB;
   assign MemWrite   = outStage.memWrite;
   assign ResultSrc  = outStage.resultSrc;
   assign Branch     = outStage.branch;
   assign BranchCond = outStage.branchCond;
   assign ALUOp      = outStage.aluOp;
   assign Jump       = outStage.jump;
   assign illegal    = outStage.illegal;
   assign ill_count  = illCntQ;

endmodule

// File: doc/control_pipe_decoder.md
Name: control_pipe_decoder

Overview:
Parametrised, registered successor to the combinational main decoder. Decodes opcode/funct3 into the full control bundle and carries it through PIPE_DEPTH pipeline stages (ID→EX and beyond), with stall, flush, bubble insertion and illegal-instruction detection. It adds full RV32I branch decoding (BEQ/BNE/BLT/BGE/BLTU/BGEU) and a saturating illegal-instruction counter.

Parameters:
PIPE_DEPTH, 1, number of register stages between decode and outputs (1..4)
BRANCH_FULL, 1, 1 = decode all six branch funct3 codes; 0 = only BEQ/BNE, all others illegal
ILL_CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  op/funct3 carry a real instruction this cycle
op  in  7  instruction opcode [6:0]
funct3  in  3  instruction funct3
stall  in  1  hold all stages
flush  in  1  kill all in-flight entries
out_valid  out  1  output stage holds a real instruction
RegWrite  out  1  register-file write enable
ImmSrc  out  3  immediate format select
ALUSrcA  out  1  0 = rs1, 1 = PC
ALUSrcB  out  2  00 rs2, 01 imm, 10 PC-target
MemWrite  out  1  data-memory write enable
ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4
Branch  out  1  conditional branch
BranchCond  out  3  branch condition, equals funct3 when Branch = 1, else 000
ALUOp  out  2  ALU decoder class
Jump  out  1  unconditional jump (jal/jalr)
illegal  out  1  output-stage entry was an illegal instruction
ill_count  out  ILL_CNT_W  saturating count of illegal instructions retired from output stage

Behaviour:
- Reset (rst_n = 0, asynchronous): every stage valid = 0, all control fields 0, illegal = 0, ill_count = 0. All outputs read 0 immediately.
- Decode table (RegWrite/ImmSrc/ALUSrcA/ALUSrcB/MemWrite/ResultSrc/Branch/ALUOp/Jump):
  - 0x03 lw: 1/000/0/01/0/01/0/00/0
  - 0x23 sw: 0/001/0/01/1/00/0/00/0
  - 0x33 R: 1/000/0/00/0/00/0/10/0
  - 0x13 I-ALU: 1/000/0/01/0/00/0/10/0
  - 0x63 B: 0/010/0/00/0/00/1/01/0, BranchCond = funct3
  - 0x6F jal: 1/011/0/00/0/10/0/00/1
  - 0x67 jalr: 1/000/0/01/0/10/0/00/1
  - 0x17 auipc: 1/100/1/10/0/00/0/00/0
  - 0x37 lui: 1/100/1/01/0/00/0/00/0
- Illegal: in_valid = 1 and (op not in table, or op = 0x63 with funct3 ∈ {010, 011}, or BRANCH_FULL = 0 with funct3 ∉ {000, 001}). An illegal entry is valid with all control fields 0 and illegal = 1, so no architectural side effects.
- op = 0x00 with in_valid = 1 is a bubble, not illegal: valid = 0, fields 0. Any in_valid = 0 entry is also a bubble.
- Pipeline: stage 0 captures the decoded bundle; stage k captures stage k-1. Outputs are driven from stage PIPE_DEPTH-1. Latency is exactly PIPE_DEPTH cycles with no stall.
- Invariant: when out_valid = 0, all control outputs, BranchCond and illegal are 0.
- stall = 1: all stages hold. Inputs are not captured, and the upstream stage must re-present them.
- flush = 1: all stages load bubbles on the next edge. Flush beats stall. The input this cycle is discarded.
- ill_count: increments by 1 on each edge where the output stage holds valid & illegal and (stall = 0 or flush = 1), i.e. when the entry leaves. It saturates at 2^ILL_CNT_W - 1 and has no wrap. A stalled illegal entry counts once, on departure.
- Reset mid-operation clears all in-flight entries. ill_count returns to 0.

Test Plan:
- Reset: rst_n low mid-stream with a lw in flight → all outputs 0 and ill_count = 0 asynchronously. After release with in_valid = 0, outputs stay 0.
- Latency, PIPE_DEPTH = 2: in_valid = 1, op = 0x03 at cycle 0 → at cycle 2 out_valid = 1, RegWrite = 1, ALUSrcB = 01, ResultSrc = 01, others 0.
- Branches: op = 0x63 with funct3 = 100 → Branch = 1, BranchCond = 100, ALUOp = 01, ImmSrc = 010. With BRANCH_FULL = 0 the same input → illegal = 1, Branch = 0, ill_count = 1.
- Stall/flush: sw issued, stall = 1 for 3 cycles → outputs frozen at MemWrite = 1. Then stall = 1 and flush = 1 together → next cycle out_valid = 0, all fields 0.
- Illegal saturation, ILL_CNT_W = 2: 5 consecutive op = 0x7F → ill_count = 1, 2, 3, 3, 3. op = 0x00 → no increment, out_valid = 0.
- jal/auipc: op = 0x6F → Jump = 1, ResultSrc = 10, ImmSrc = 011. op = 0x17 → ALUSrcA = 1, ALUSrcB = 10, ImmSrc = 100.
